motion_control: RTL and testbench
=================================

# motion_control

Elevator motion and door sequencer for the 2-way, 7-floor car. Consumes the latched hall and car button vectors from the button-latch stage and decides where the car goes. Produces the registered car position, travel direction, door state and move flag that the button-latch stage uses to clear served requests. Uses collective (same-direction-first) scheduling, with a per-floor travel timer and a door dwell timer.

## Interface
- `TRAVEL_CYCLES`, 4: clock cycles to travel one floor (1–255).
- `DOOR_CYCLES`, 6: clock cycles the door stays open (1–255).

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low. Low forces reset immediately; release is sampled on `clk`.
- `floorButton`  in  14  hall requests, two bits per floor f = 1..7:
  - bit 2(f−1) = DOWN request.
  - bit 2(f−1)+1 = UP request.
- `internalButton`  in  9 ([9:1])  car requests:
  - [7:1] = floor requests.
  - [8] = door-open request.
  - [9] = door-close request.
- `currentFloor`  out  3  car floor, 1..7.
- `currentDirection`  out  2  STOP=00, UP=10, DOWN=01 (11 never driven).
- `doorState`  out  1  OPEN=1, CLOSE=0.
- `move`  out  1  MOVE=1, HOLD=0.
- `buttonEnable`  out  1  one-cycle strobe telling the button stage to update (clear served requests).

## Operation
- **States:** IDLE, MOVING, DOOR_OPEN. An 8-bit down-counter `timer` is shared by MOVING and DOOR_OPEN.
- **Derived terms** (combinational, from the current inputs):
  - reqAt(f) = internalButton[f] | either hall bit of f.
  - reqAbove = any reqAt(g) with g > currentFloor.
  - reqBelow = any reqAt(g) with g < currentFloor.
  - stopHere (while moving in direction d) = internalButton[f] | hall bit for d at f | (no requests beyond f in d).
- **IDLE** (door CLOSE, move HOLD). Priority order:
  1. reqAt(currentFloor): go to DOOR_OPEN. Direction becomes UP if the UP hall bit is set, else DOWN if the DOWN hall bit is set, else it is kept.
  2. Requests in the retained direction (reqAbove for UP, reqBelow for DOWN): go to MOVING in that direction.
  3. Otherwise reqAbove: go to MOVING UP. Else reqBelow: go to MOVING DOWN.
  4. Otherwise stay in IDLE with direction STOP.
- **MOVING** (move MOVE, door CLOSE):
  - Entry loads timer = TRAVEL_CYCLES−1. The timer decrements each cycle.
  - At 0, currentFloor steps ±1.
  - Then, if stopHere at the new floor, or the new floor is 7 going UP, or 1 going DOWN: go to DOOR_OPEN and set move = HOLD.
  - Otherwise reload the timer and keep moving.
  - currentFloor never leaves 1..7.
- **DOOR_OPEN** (door OPEN, move HOLD):
  - Entry loads timer = DOOR_CYCLES−1.
  - At 0, go to IDLE with door CLOSE. The direction is kept so IDLE prefers it.
- **buttonEnable** pulses for 1 cycle on every state entry, and every cycle while in DOOR_OPEN, so the button stage clears the served floor and direction bits.
- All outputs are registered. None of them depends combinationally on the inputs.

## Timing
- **Reset values:** currentFloor=1, currentDirection=STOP, doorState=CLOSE, move=HOLD, buttonEnable=0, state=IDLE, timer=0.
- **Request to motion:** a request first visible at edge n causes the state change at edge n+1.
- **Floor travel:** exactly TRAVEL_CYCLES cycles per floor. currentFloor updates on the same edge as the timer expiry.
- **Door dwell:** doorState is high for exactly DOOR_CYCLES cycles, unless modified as described under Configuration.
- **Requests arriving mid-travel:**
  - A request for a floor not yet reached is honoured at that floor.
  - A request for the floor just left is served on the return trip.
- **Simultaneous requests above and below with no retained direction:** UP wins.
- **Reset asserted mid-travel or mid-dwell:** all outputs return immediately to their reset values. No partial floor step is kept.

## Configuration
- Macro: `DOOR_BUTTON_EN`.
- **Defined:**
  - internalButton[8] held in DOOR_OPEN reloads timer = DOOR_CYCLES−1 every cycle.
  - internalButton[9] in DOOR_OPEN forces timer to 0, so the door closes on the next edge.
  - [8] in IDLE, at a floor with the car stopped, reopens the door (goes to DOOR_OPEN).
  - If [8] and [9] are both set, [8] wins.
- **Undefined:** internalButton[9:8] are ignored in every state. Dwell is always exactly DOOR_CYCLES.

## Test plan
- **Reset:** release reset at floor 1 with no requests. Required: floor=1, dir=00, door=0, move=0, stays in IDLE indefinitely.
- **Car call:** internalButton[4] from IDLE at floor 1 with TRAVEL_CYCLES=4. Required:
  - dir=10, move=1.
  - floor reads 2, 3, 4 at 4-cycle spacing.
  - At floor 4: move=0, door=1 for 6 cycles, then door=0 and dir=10 retained.
- **Collective ordering:** car moving UP between floors 2 and 3; hall DOWN at 3 (bit 4) plus car call 6. Required:
  - Passes floor 3 without stopping.
  - Stops at 6, then services 3 heading DOWN.
- **Boundary:** hall UP at floor 7 (bit 13) while at floor 7. Required: door opens with no motion. Floor never exceeds 7 or goes below 1 in a randomized 10k-cycle run.
- **Door buttons (`DOOR_BUTTON_EN` defined):**
  - Hold [8] for 10 cycles in DOOR_OPEN: door stays 1 until 6 cycles after release.
  - Pulse [9]: door=0 on the following edge.
  - With the macro undefined: both buttons have no effect.
- **Async reset mid-travel:** assert reset low 2 cycles into a floor 3→4 travel. Required: outputs go to reset values without waiting for a clock edge, and the state machine restarts in IDLE on release.

Source files
------------

// File: rtl/motion_control_if.sv
// Request and status bundle between the button-latch stage and the motion sequencer.
interface motion_control_if;
  logic [13:0] floorButton;
  logic [9:1]  internalButton;
  logic [2:0]  currentFloor;
  logic [1:0]  currentDirection;
  logic        doorState;
  logic        move;
  logic        buttonEnable;

  // Button-latch side: drives requests, observes car status.
  modport master (
    output floorButton, internalButton,
    input  currentFloor, currentDirection, doorState, move, buttonEnable
  );

  // Sequencer side.
  modport slave (
    input  floorButton, internalButton,
    output currentFloor, currentDirection, doorState, move, buttonEnable
  );
endinterface

// File: rtl/motion_control.sv
// Collective-scheduling motion and door sequencer for a 7-floor elevator car.
// Define DOOR_BUTTON_EN to enable the car door-open/door-close buttons.
module motion_control #(
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 6
) (
  input  logic            clk,
  input  logic            reset,
  motion_control_if.slave bus
);
  localparam int unsigned TIMER_W    = 8;
  localparam int unsigned FLOOR_W    = 3;
  localparam int unsigned NUM_FLOORS = 7;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DOWN = 2'b01;

  localparam logic [TIMER_W-1:0] TRAVEL_LOAD  = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD    = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR    = FLOOR_W'(NUM_FLOORS);
  localparam logic [FLOOR_W-1:0] BOTTOM_FLOOR = FLOOR_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVING = 2'd1, DOOR_OPEN = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic [FLOOR_W-1:0]   floor, floor_nxt;
  logic [1:0]           dir, dir_nxt;
  logic                 door, door_nxt;
  logic                 mv, mv_nxt;
  logic                 be, be_nxt;

  logic [NUM_FLOORS:0]  car, hall_up, hall_dn, req_at;
  logic                 req_above, req_below, beyond, stop_here, reopen;
  logic [FLOOR_W-1:0]   step;
  logic [1:0]           go_dir;

  // Per-floor request decode; index 0 is unused so floor numbers index directly.
  always_comb begin
    car     = '0;
    hall_up = '0;
    hall_dn = '0;
    for (int unsigned f = 1; f <= NUM_FLOORS; f++) begin
      car[FLOOR_W'(f)]     = bus.internalButton[4'(f)];
      hall_dn[FLOOR_W'(f)] = bus.floorButton[4'(2 * f - 2)];
      hall_up[FLOOR_W'(f)] = bus.floorButton[4'(2 * f - 1)];
    end
    req_at = car | hall_up | hall_dn;
  end

  // Floor reached at the end of the current leg, and whether the car should stop there.
  always_comb begin
    step = floor;
    if (dir == DIR_UP && floor != TOP_FLOOR)
      step = floor + FLOOR_W'(1);
    else if (dir == DIR_DOWN && floor != BOTTOM_FLOOR)
      step = floor - FLOOR_W'(1);

    req_above = 1'b0;
    req_below = 1'b0;
    beyond    = 1'b0;
    for (int unsigned g = 1; g <= NUM_FLOORS; g++) begin
      if (req_at[FLOOR_W'(g)] && FLOOR_W'(g) > floor) req_above = 1'b1;
      if (req_at[FLOOR_W'(g)] && FLOOR_W'(g) < floor) req_below = 1'b1;
      if (req_at[FLOOR_W'(g)] && dir == DIR_UP   && FLOOR_W'(g) > step) beyond = 1'b1;
      if (req_at[FLOOR_W'(g)] && dir == DIR_DOWN && FLOOR_W'(g) < step) beyond = 1'b1;
    end

    stop_here = car[step] | !beyond |
                ((dir == DIR_UP) ? hall_up[step] : hall_dn[step]);
  end

`ifdef DOOR_BUTTON_EN
  assign reopen = bus.internalButton[8];
`else
  assign reopen = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    floor_nxt = floor;
    dir_nxt   = dir;
    door_nxt  = door;
    mv_nxt    = mv;
    go_dir    = DIR_STOP;

    case (state)
      IDLE: begin
        door_nxt = 1'b0;
        mv_nxt   = 1'b0;
        if (req_at[floor] || reopen) begin
          state_nxt = DOOR_OPEN;
          timer_nxt = DOOR_LOAD;
          door_nxt  = 1'b1;
          if (hall_up[floor])      dir_nxt = DIR_UP;
          else if (hall_dn[floor]) dir_nxt = DIR_DOWN;
        end else begin
          if ((dir == DIR_UP && req_above) || (dir == DIR_DOWN && req_below)) go_dir = dir;
          else if (req_above)                                                 go_dir = DIR_UP;
          else if (req_below)                                                 go_dir = DIR_DOWN;
          dir_nxt = go_dir;
          if (go_dir != DIR_STOP) begin
            state_nxt = MOVING;
            timer_nxt = TRAVEL_LOAD;
            mv_nxt    = 1'b1;
          end
        end
      end

      MOVING: begin
        if (timer != '0) begin
          timer_nxt = timer - TIMER_W'(1);
        end else begin
          floor_nxt = step;
          if (stop_here || step == TOP_FLOOR || step == BOTTOM_FLOOR || dir == DIR_STOP) begin
            state_nxt = DOOR_OPEN;
            timer_nxt = DOOR_LOAD;
            door_nxt  = 1'b1;
            mv_nxt    = 1'b0;
          end else begin
            timer_nxt = TRAVEL_LOAD;
          end
        end
      end

      DOOR_OPEN: begin
`ifdef DOOR_BUTTON_EN
        if (bus.internalButton[8]) begin
          timer_nxt = DOOR_LOAD;
        end else if (timer == '0) begin
          state_nxt = IDLE;
          door_nxt  = 1'b0;
        end else if (bus.internalButton[9]) begin
          timer_nxt = '0;
        end else begin
          timer_nxt = timer - TIMER_W'(1);
        end
`else
        if (timer == '0) begin
          state_nxt = IDLE;
          door_nxt  = 1'b0;
        end else begin
          timer_nxt = timer - TIMER_W'(1);
        end
`endif
      end

      default: begin
        state_nxt = IDLE;
        door_nxt  = 1'b0;
        mv_nxt    = 1'b0;
      end
    endcase

    be_nxt = (state_nxt != state) || (state_nxt == DOOR_OPEN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
      floor <= BOTTOM_FLOOR;
      dir   <= DIR_STOP;
      door  <= 1'b0;
      mv    <= 1'b0;
      be    <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      floor <= floor_nxt;
      dir   <= dir_nxt;
      door  <= door_nxt;
      mv    <= mv_nxt;
      be    <= be_nxt;
    end
  end

  assign bus.currentFloor     = floor;
  assign bus.currentDirection = dir;
  assign bus.doorState        = door;
  assign bus.move             = mv;
  assign bus.buttonEnable     = be;
endmodule

// File: tb/tb_motion_control.sv
// Self-checking bench for motion_control: stop-event scoreboard, request table, corner sequences.
module tb_motion_control;
  localparam int unsigned TRAVEL = 4;
  localparam int unsigned DOOR   = 6;
  localparam logic [1:0]  UP = 2'b10;
  localparam logic [1:0]  DN = 2'b01;
  localparam logic [1:0]  ST = 2'b00;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  motion_control_if bus ();

  motion_control #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] fl;
    logic [1:0] dir;
  } stop_t;

  typedef struct {
    logic [13:0] fb;
    logic [9:1]  ib;
    int          nstops;
    logic [2:0]  f0;
    logic [1:0]  d0;
    logic [2:0]  f1;
    logic [1:0]  d1;
  } vec_t;

  stop_t sb[$];
  vec_t  vecs[12];
  int    n_pass = 0;
  int    n_total = 0;
  int    dwell = 0;
  int    fmin = 1;
  int    fmax = 1;
  bit    door_prev = 1'b0;
  bit    be_bad = 1'b0;
  bit    sb_on = 1'b1;
  bit    dwell_on = 1'b1;

  function automatic logic [9:1] ibit(input int f);
    logic [9:1] v;
    v = '0;
    v[4'(f)] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One cycle: sample at negedge, score door openings and dwell, clear served requests.
  task automatic tick();
    int    fi;
    stop_t e;
    @(negedge clk);
    fi = int'(bus.currentFloor);
    if (reset) begin
      if (fi < fmin) fmin = fi;
      if (fi > fmax) fmax = fi;
    end
    if (bus.doorState && !door_prev) begin
      dwell  = 0;
      be_bad = 1'b0;
      if (sb_on) begin
        chk("stop_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("stop_floor", fi, int'(e.fl));
          chk("stop_dir", int'(bus.currentDirection), int'(e.dir));
        end
      end
    end
    if (bus.doorState) begin
      dwell++;
      if (!bus.buttonEnable) be_bad = 1'b1;
      bus.internalButton[4'(fi)]     = 1'b0;
      bus.floorButton[4'(2 * fi - 2)] = 1'b0;
      bus.floorButton[4'(2 * fi - 1)] = 1'b0;
    end else if (door_prev && dwell_on) begin
      chk("door_dwell", dwell, int'(DOOR));
      chk("enable_during_door", int'(be_bad), 0);
    end
    door_prev = bus.doorState;
  endtask

  task automatic wait_door(input string name, input logic val);
    int t;
    t = 0;
    while (bus.doorState != val && t < 100) begin
      tick();
      t++;
    end
    chk(name, int'(bus.doorState), int'(val));
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while ((sb.size() != 0 || bus.doorState || bus.move ||
                (|bus.floorButton) || (|bus.internalButton[7:1])) && t < 3000);
    chk("sequence_complete", int'(t < 3000), 1);
    sb.delete();
    repeat (3) tick();
  endtask

  task automatic set_vec(input int i, input logic [13:0] fb, input logic [9:1] ib, input int n,
                         input logic [2:0] f0, input logic [1:0] d0,
                         input logic [2:0] f1, input logic [1:0] d1);
    vecs[i] = '{fb: fb, ib: ib, nstops: n, f0: f0, d0: d0, f1: f1, d1: d1};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int cnt;
    int t;

    // Starts at floor 4 (end of the car-call sequence) with direction STOP.
    set_vec(0,  14'h0004, '0, 1, 3'd2, DN, 3'd0, ST);
    set_vec(1,  14'h0200, '0, 1, 3'd5, UP, 3'd0, ST);
    set_vec(2,  14'h0000, ibit(5), 1, 3'd5, ST, 3'd0, ST);
    set_vec(3,  14'h2000, '0, 1, 3'd7, UP, 3'd0, ST);
    set_vec(4,  14'h2000, '0, 1, 3'd7, UP, 3'd0, ST);
    set_vec(5,  14'h0000, ibit(1), 1, 3'd1, DN, 3'd0, ST);
    set_vec(6,  14'h0001, '0, 1, 3'd1, DN, 3'd0, ST);
    set_vec(7,  14'h1000, '0, 1, 3'd7, UP, 3'd0, ST);
    set_vec(8,  14'h0040, '0, 1, 3'd4, DN, 3'd0, ST);
    set_vec(9,  14'h0000, ibit(6) | ibit(2), 2, 3'd6, UP, 3'd2, DN);
    set_vec(10, 14'h0008, '0, 1, 3'd2, UP, 3'd0, ST);
    set_vec(11, 14'h0002, '0, 1, 3'd1, DN, 3'd0, ST);

    bus.floorButton    = '0;
    bus.internalButton = '0;

    // Reset values, during and after reset.
    #1 reset = 1'b0;
    tick();
    chk("rst_floor", int'(bus.currentFloor), 1);
    chk("rst_dir", int'(bus.currentDirection), int'(ST));
    chk("rst_door", int'(bus.doorState), 0);
    chk("rst_move", int'(bus.move), 0);
    tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("idle_floor", int'(bus.currentFloor), 1);
    chk("idle_dir", int'(bus.currentDirection), int'(ST));
    chk("idle_door", int'(bus.doorState), 0);
    chk("idle_move", int'(bus.move), 0);
    chk("idle_enable", int'(bus.buttonEnable), 0);

    // Car call to floor 4: per-floor timing and arrival.
    bus.internalButton = ibit(4);
    sb.push_back('{3'd4, UP});
    tick();
    chk("call_move", int'(bus.move), 1);
    chk("call_dir", int'(bus.currentDirection), int'(UP));
    chk("call_enable", int'(bus.buttonEnable), 1);
    for (int k = 2; k <= 4; k++) begin
      prev = int'(bus.currentFloor);
      cnt  = 0;
      do begin
        tick();
        cnt++;
        if (k == 2 && cnt == 1) chk("enable_one_cycle", int'(bus.buttonEnable), 0);
      end while (int'(bus.currentFloor) == prev && cnt < 20);
      chk("travel_cycles", cnt, int'(TRAVEL));
      chk("floor_step", int'(bus.currentFloor), k);
    end
    chk("arrive_move", int'(bus.move), 0);
    chk("arrive_door", int'(bus.doorState), 1);
    wait_door("door_closes", 1'b0);
    chk("dir_retained", int'(bus.currentDirection), int'(UP));
    repeat (2) tick();
    chk("idle_dir_stop", int'(bus.currentDirection), int'(ST));

    // Request table.
    for (int i = 0; i < 12; i++) begin
      sb.push_back('{vecs[i].f0, vecs[i].d0});
      if (vecs[i].nstops > 1) sb.push_back('{vecs[i].f1, vecs[i].d1});
      bus.floorButton    = bus.floorButton | vecs[i].fb;
      bus.internalButton = bus.internalButton | vecs[i].ib;
      wait_done();
    end

    // Collective ordering: hall DOWN at 3 raised while travelling 2->3 toward 6.
    bus.internalButton = ibit(6);
    sb.push_back('{3'd6, UP});
    sb.push_back('{3'd3, DN});
    t = 0;
    while (!(bus.move && bus.currentFloor == 3'd2) && t < 50) begin
      tick();
      t++;
    end
    chk("collective_at_2", int'(bus.currentFloor), 2);
    bus.floorButton[4] = 1'b1;
    wait_done();

    // Async reset two cycles into a 3->4 travel.
    bus.internalButton = ibit(4);
    t = 0;
    while (!bus.move && t < 20) begin
      tick();
      t++;
    end
    chk("rt_moving", int'(bus.move), 1);
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    chk("rt_floor", int'(bus.currentFloor), 1);
    chk("rt_dir", int'(bus.currentDirection), int'(ST));
    chk("rt_door", int'(bus.doorState), 0);
    chk("rt_move", int'(bus.move), 0);
    chk("rt_enable", int'(bus.buttonEnable), 0);
    bus.internalButton = '0;
    bus.floorButton    = '0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("rt_idle_floor", int'(bus.currentFloor), 1);
    chk("rt_idle_move", int'(bus.move), 0);
    chk("rt_idle_door", int'(bus.doorState), 0);
    bus.internalButton = ibit(2);
    sb.push_back('{3'd2, UP});
    wait_done();

`ifdef DOOR_BUTTON_EN
    // Door buttons active: hold extends dwell, reopen from IDLE, close cuts dwell short.
    sb_on    = 1'b0;
    dwell_on = 1'b0;
    bus.internalButton = ibit(2);
    wait_door("db_open", 1'b1);
    bus.internalButton[8] = 1'b1;
    repeat (10) tick();
    chk("db_hold_open", int'(bus.doorState), 1);
    bus.internalButton[8] = 1'b0;
    cnt = 0;
    while (bus.doorState && cnt < 30) begin
      tick();
      cnt++;
    end
    chk("db_release_dwell", cnt, int'(DOOR));
    bus.internalButton[8] = 1'b1;
    tick();
    chk("db_reopen", int'(bus.doorState), 1);
    bus.internalButton[8] = 1'b0;
    tick();
    bus.internalButton[9] = 1'b1;
    tick();
    bus.internalButton[9] = 1'b0;
    chk("db_close_pending", int'(bus.doorState), 1);
    tick();
    chk("db_close", int'(bus.doorState), 0);
    repeat (4) tick();
    sb_on    = 1'b1;
    dwell_on = 1'b1;
`else
    // Door buttons ignored: no reopen from IDLE, close button does not shorten dwell.
    bus.internalButton[8] = 1'b1;
    repeat (5) tick();
    chk("db_no_reopen", int'(bus.doorState), 0);
    chk("db_no_move", int'(bus.move), 0);
    bus.internalButton[8] = 1'b0;
    bus.internalButton = ibit(2);
    sb.push_back('{3'd2, ST});
    wait_door("db_open", 1'b1);
    bus.internalButton[9] = 1'b1;
    repeat (3) tick();
    chk("db_close_ignored", int'(bus.doorState), 1);
    bus.internalButton[9] = 1'b0;
    wait_done();
`endif

    // Random request storm; floor must stay within 1..7.
    sb_on = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      int r;
      tick();
      if ($urandom_range(0, 15) == 0) begin
        r = int'($urandom_range(0, 20));
        if (r < 14) bus.floorButton[4'(r)] = 1'b1;
        else        bus.internalButton[4'(r - 13)] = 1'b1;
      end
    end
    bus.floorButton    = '0;
    bus.internalButton = '0;
    chk("floor_min", int'(fmin >= 1), 1);
    chk("floor_max", int'(fmax <= 7), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
